// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, FSM state type and round helper functions
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_H_0.sv
// rtl/sha256_H_0.sv - drives the SHA-256 initial hash value for the first block of a message
module sha256_H_0
    import sha256_pkg::*;
(
    output logic [255:0] H_0
);

    assign H_0 = IV;

endmodule

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round over packed a..h
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign t1 = h + S1(e) + Ch(e, f, g) + k + w;
    assign t2 = S0(a) + Maj(a, b, c);

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block.sv
// rtl/sha256_block.sv - iterative SHA-256 compression, one round per clock, 66-cycle turnaround
module sha256_block
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] H_in,
    input  logic [511:0] M_in,
    input  logic         input_valid,
    output logic [255:0] H_out,
    output logic         output_valid
);

    state_t       state;
    logic [255:0] work;
    logic [255:0] work_next;
    logic [255:0] saved_h;
    logic [31:0]  sched [16];
    logic [5:0]   round_cnt;
    logic [31:0]  w_new;

    // sched[0] always holds W[t]; the new tail word is W[t+16]
    assign w_new = s1(sched[14]) + sched[9] + s0(sched[1]) + sched[0];

    sha256_round u_round (
        .state_in  (work),
        .k         (K[round_cnt]),
        .w         (sched[0]),
        .state_out (work_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            work         <= '0;
            saved_h      <= '0;
            round_cnt    <= '0;
            H_out        <= '0;
            output_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sched[i] <= '0;
            end
        end else begin
            output_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        work      <= H_in;
                        saved_h   <= H_in;
                        round_cnt <= '0;
                        for (int i = 0; i < 16; i++) begin
                            sched[i] <= M_in[511 - 32*i -: 32];
                        end
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    work      <= work_next;
                    round_cnt <= round_cnt + 6'd1;
                    for (int i = 0; i < 15; i++) begin
                        sched[i] <= sched[i+1];
                    end
                    sched[15] <= w_new;
                    if (round_cnt == 6'd63) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    for (int i = 0; i < 8; i++) begin
                        H_out[255 - 32*i -: 32] <= saved_h[255 - 32*i -: 32] + work[255 - 32*i -: 32];
                    end
                    output_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block.sv
// tb/tb_sha256_block.sv - self-checking bench for sha256_block against a float-derived SHA-256 model
module tb_sha256_block;

    logic         clk;
    logic         rst;
    logic [255:0] H_in;
    logic [511:0] M_in;
    logic         input_valid;
    logic [255:0] H_out;
    logic         output_valid;
    logic [255:0] H_0;

    int checks = 0;
    int errors = 0;

    logic [31:0]  kk [64];
    logic [255:0] iv_ref;

    sha256_block dut (
        .clk          (clk),
        .rst          (rst),
        .H_in         (H_in),
        .M_in         (M_in),
        .input_valid  (input_valid),
        .H_out        (H_out),
        .output_valid (output_valid)
    );

    sha256_H_0 u_iv (.H_0(H_0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] frac32(input real r);
        real f;
        f = r - $floor(r);
        return 32'(longint'($floor(f * 4294967296.0)));
    endfunction

    // Constants from their definition: fractional parts of cube/square roots of the first primes
    task automatic init_consts();
        int n = 0;
        int p = 2;
        while (n < 64) begin
            bit is_prime = 1'b1;
            for (int d = 2; d * d <= p; d++) begin
                if (p % d == 0) is_prime = 1'b0;
            end
            if (is_prime) begin
                kk[n] = frac32($pow(real'(p), 1.0 / 3.0));
                if (n < 8) iv_ref[255 - 32*n -: 32] = frac32($sqrt(real'(p)));
                n++;
            end
            p++;
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        return {rand256(), rand256()};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the falling edge right after the start edge
    task automatic start_block(input logic [255:0] h, input logic [511:0] m);
        @(negedge clk);
        H_in = h;
        M_in = m;
        input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        H_in = rand256();
        M_in = rand512();
    endtask

    task automatic wait_pulse(input int base, output int lat);
        lat = base;
        do begin
            @(negedge clk);
            lat++;
        end while (!output_valid && lat < 200);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (output_valid) n++;
        end
    endtask

    task automatic expect_block(input string tag, input logic [255:0] h, input logic [511:0] m,
                                input logic [255:0] exp);
        int lat;
        start_block(h, m);
        wait_pulse(0, lat);
        check({tag, " latency"}, 256'(lat), 256'd65);
        check({tag, " digest"}, H_out, exp);
        @(negedge clk);
        check({tag, " pulse end"}, 256'(output_valid), 256'd0);
        check({tag, " hold"}, H_out, exp);
    endtask

    localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] NULL_BLK = {32'h80000000, 480'd0};
    localparam logic [511:0] ONE_BLK  = {32'h31800000, 448'd0, 32'h00000008};
    localparam logic [511:0] TWO_B1   = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] TWO_B2   = {448'd0, 32'h00000000, 32'h000001c0};
    localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] NULL_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ONE_DIG  = 256'h6b86b273ff34fce19d6b804eff5a3f5747ada4eaa22f1d49c01e52ddb7875b4b;
    localparam logic [255:0] TWO_DIG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    initial begin
        logic [255:0] h1, rh, rexp;
        logic [511:0] rm;
        int lat, n;

        rst = 1'b0;
        input_valid = 1'b0;
        H_in = '0;
        M_in = '0;
        init_consts();

        repeat (2) @(negedge clk);
        check("reset H_out", H_out, 256'd0);
        check("reset output_valid", 256'(output_valid), 256'd0);
        check("iv module", H_0, iv_ref);
        rst = 1'b1;

        expect_block("abc", iv_ref, ABC_BLK, ABC_DIG);
        expect_block("null", iv_ref, NULL_BLK, NULL_DIG);
        expect_block("one", iv_ref, ONE_BLK, ONE_DIG);

        expect_block("two b1", iv_ref, TWO_B1, ref_compress(iv_ref, TWO_B1));
        h1 = H_out;
        expect_block("two b2", h1, TWO_B2, TWO_DIG);

        // Second start request mid-computation must be dropped, not queued
        rh = rand256();
        rm = rand512();
        start_block(rh, rm);
        repeat (9) @(negedge clk);
        H_in = rand256();
        M_in = rand512();
        input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        wait_pulse(10, lat);
        check("ignore latency", 256'(lat), 256'd65);
        check("ignore digest", H_out, ref_compress(rh, rm));
        count_pulses(80, n);
        check("ignore extra pulses", 256'(n), 256'd0);

        // Reset mid-computation aborts immediately
        start_block(iv_ref, ABC_BLK);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort H_out", H_out, 256'd0);
        check("abort output_valid", 256'(output_valid), 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        count_pulses(80, n);
        check("abort pulses", 256'(n), 256'd0);
        expect_block("abc after abort", iv_ref, ABC_BLK, ABC_DIG);

        // Random back-to-back blocks, each started on the first edge back in IDLE
        rh = rand256();
        rm = rand512();
        @(negedge clk);
        H_in = rh;
        M_in = rm;
        input_valid = 1'b1;
        for (int it = 0; it < 6; it++) begin
            rexp = ref_compress(rh, rm);
            @(negedge clk);
            if (it > 0) check("b2b idle gap", 256'(output_valid), 256'd0);
            input_valid = 1'b0;
            H_in = rand256();
            M_in = rand512();
            wait_pulse(0, lat);
            check("b2b latency", 256'(lat), 256'd65);
            check("b2b digest", H_out, rexp);
            if (it < 5) begin
                rh = rand256();
                rm = rand512();
                H_in = rh;
                M_in = rm;
                input_valid = 1'b1;
            end
        end
        @(negedge clk);
        check("b2b final pulse end", 256'(output_valid), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_block.md
SHA256_BLOCK -- requirements
Module: sha256_block

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by SHA-256 (FIPS 180-4).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 H_in  input  256  chaining value, word H0 in [255:224] down to H7 in [31:0].
REQ-005 M_in  input  512  padded message block, big-endian, word W0 in [511:480] down to W15 in [31:0].
REQ-006 input_valid  input  1  start request, sampled on the rising edge.
REQ-007 H_out  output  256  updated chaining value, same word order as H_in.
REQ-008 output_valid  output  1  single-cycle pulse marking a new H_out.

Function
REQ-009 The block SHALL compute one SHA-256 compression of M_in with H_in; all arithmetic is 32-bit modulo 2^32.
REQ-010 States SHALL be IDLE, ROUND and DONE.
REQ-011 IDLE: on an edge with input_valid=1, the block SHALL register H_in into a..h and into a saved-H register, load M_in into the 16-word schedule window, clear the round counter and go to ROUND.
REQ-012 ROUND: each edge SHALL perform round t (t=0..63) using K[t] and W[t].
- W[t] = M word t for t<16.
- W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] for t>=16.
- The window is a 16x32 shift register.
REQ-013 After round 63 the block SHALL go to DONE.
REQ-014 DONE: on that edge the block SHALL load H_out with saved-H word i + working variable i for every i, assert output_valid for exactly one cycle, then return to IDLE.
REQ-015 Latency: with input_valid sampled at edge k, H_out and output_valid=1 SHALL be visible after edge k+65, and output_valid SHALL be 0 after edge k+66.
REQ-016 H_out SHALL hold its value until the next completion.
REQ-017 input_valid in ROUND or DONE SHALL be ignored; it is not queued.
REQ-018 H_in and M_in SHALL be sampled only on the start edge and may change afterwards.
REQ-019 A new start SHALL be accepted at the first edge in IDLE, so back-to-back blocks run every 66 cycles.
REQ-020 Multi-block messages SHALL be handled externally by feeding H_out back as H_in.

Reset
REQ-021 While rst=0 the block SHALL immediately enter IDLE.
- H_out = 0, output_valid = 0.
- Round counter, working variables and schedule cleared.
REQ-022 Reset asserted mid-computation SHALL abort it with no output_valid pulse.
REQ-023 After rst rises, the first accepted start SHALL be on an edge with rst=1 and input_valid=1.

Structure
REQ-024 A shared package sha256_pkg SHALL hold:
- the 64-entry K round-constant table;
- the 256-bit IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19;
- the functions Ch, Maj, S0, S1, s0 and s1.
REQ-025 Companion module sha256_H_0 (output H_0, 256 bits, purely combinational) SHALL drive the IV from the package.
REQ-026 sha256_block MAY contain one sub-module, sha256_round, a combinational round function taking a..h, K and W and returning the next a..h.

Verification
REQ-027 "abc" block (61626380 followed by zeros, last word 00000018) with H_in = IV -> after 65 cycles output_valid=1 and H_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-028 Null block (80000000 followed by zeros) with IV -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-029 "1" block (31800000 followed by zeros, last word 00000008) with IV -> 6b86b273ff34fce19d6b804eff5a3f5747ada4eaa22f1d49c01e52ddb7875b4b.
REQ-030 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second block chained from the first H_out -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-031 input_valid pulsed again 10 cycles after a start -> ignored; exactly one output_valid pulse with the first result.
REQ-032 rst pulled low 30 cycles into a computation -> H_out=0 and output_valid=0 at once, no pulse afterwards; a fresh "abc" start then produces the correct digest.
